// File: rtl/proj_decim.sv
// Block-average decimator: averages N = 2^DECIM_LOG2 signed samples with round-half-up and
// queues each average in a first-word-fall-through FIFO with a sticky overflow flag.
module proj_decim #(
  parameter int unsigned DECIM_LOG2 = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    y_in,
  input  logic                          in_valid,
  input  logic                          flush,
  output logic [7:0]                    dout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int unsigned N    = 1 << DECIM_LOG2;
  localparam int unsigned AccW = 8 + DECIM_LOG2;
  localparam int unsigned CntW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int unsigned Rnd  = N / 2;
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  // ---------------------------------------------------------------------------------------------
  // Accumulator and sample counter
  // ---------------------------------------------------------------------------------------------
  logic signed [AccW-1:0] acc_q, acc_d;
  logic        [CntW-1:0] cnt_q, cnt_d;
  logic signed [AccW-1:0] samp_ext;
  logic signed [AccW-1:0] sum;
  logic signed [AccW:0]   rnd_sum;
  logic signed [AccW:0]   avg_full;
  logic        [7:0]      avg;
  logic                   accept;
  logic                   last;

  assign accept   = in_valid & ~flush;
  assign last     = (cnt_q == CntW'(N - 1));
  assign samp_ext = AccW'($signed(y_in));
  assign sum      = acc_q + samp_ext;

  // One extra bit of headroom; the shifted result always fits in 8 bits.
  always_comb begin
    rnd_sum  = (AccW + 1)'(sum);
    rnd_sum  = rnd_sum + (AccW + 1)'(Rnd);
    avg_full = rnd_sum >>> DECIM_LOG2;
    avg      = avg_full[7:0];
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (in_valid) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------------------------
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_q, wr_d;
  logic [PtrW-1:0] rd_q, rd_d;
  logic [LvlW-1:0] lvl_q, lvl_d;
  logic            ovf_q, ovf_d;
  logic            push_req;
  logic            do_push;
  logic            do_pop;
  logic            full;
  logic            ovf_set;

  assign push_req = accept & last;
  assign full     = (lvl_q == LvlW'(FIFO_DEPTH));
  assign do_pop   = (lvl_q != '0) & out_ready;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign do_push  = push_req & (~full | do_pop);
  assign ovf_set  = push_req & full & ~do_pop;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (do_push) begin
      wr_d = wr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   lvl_d = lvl_q + LvlW'(1);
      2'b01:   lvl_d = lvl_q - LvlW'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  // New overflow wins over a coincident clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= avg;
    end
  end

  // Storage is not reset, so the head is masked while empty to present 0.
  assign out_valid = (lvl_q != '0);
  assign dout      = out_valid ? mem_q[rd_q] : 8'h00;
  assign level     = lvl_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/proj_decim.md
PROJ_DECIM -- requirements
Module: proj_decim

Interface
REQ-001: Parameter DECIM_LOG2, default 2, sets the block length N = 2^DECIM_LOG2 samples per output (legal range 0..4).
REQ-002: Parameter FIFO_DEPTH, default 4, sets the output FIFO entries (power of two, at least 2).
REQ-003: Port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge except at reset.
REQ-004: Port reset, input, 1 bit, asynchronous active-low reset (0 = reset asserted).
REQ-005: Port y_in, input, 8 bits, signed filter output sample, taken directly from the upstream IIR filter stage.
REQ-006: Port in_valid, input, 1 bit, marks y_in as a sample to accept on this edge.
REQ-007: Port flush, input, 1 bit, synchronous discard of the partial block.
REQ-008: Port dout, output, 8 bits, signed decimated average at the FIFO head.
REQ-009: Port out_valid, output, 1 bit, high when the FIFO is non-empty.
REQ-010: Port out_ready, input, 1 bit, consumer accepts dout when out_ready and out_valid are both high at an edge.
REQ-011: Port level, output, clog2(FIFO_DEPTH)+1 bits, current FIFO occupancy.
REQ-012: Port ovf, output, 1 bit, sticky overflow flag.
REQ-013: Port ovf_clr, input, 1 bit, synchronous clear of ovf.

Function
REQ-014: The block SHALL accept y_in on every edge where in_valid=1 and flush=0, with no backpressure upstream.
REQ-015: A sample counter SHALL run 0..N-1, increment per accepted sample, and wrap to 0 on the Nth sample.
REQ-016: The accumulator SHALL be 8+DECIM_LOG2 bits signed and sign-extend each sample, so it never overflows.
REQ-017: On the edge accepting the Nth sample, avg = (sum + 2^(DECIM_LOG2-1)) >>> DECIM_LOG2 SHALL be computed, where sum includes that sample; the rounding term is 0 when DECIM_LOG2=0.
REQ-018: avg SHALL always lie in -128..127, so no saturation logic is required.
REQ-019: On that same edge, avg SHALL be pushed into the FIFO and the accumulator SHALL be cleared to 0.
REQ-020: The FIFO SHALL be first-word-fall-through: out_valid and dout SHALL update in the cycle after the push edge, giving 1-cycle latency into an empty FIFO.
REQ-021: On a pop (out_valid & out_ready at an edge), the head SHALL advance; pops when empty SHALL be ignored.
REQ-022: Simultaneous push and pop when full SHALL both succeed, leaving level unchanged.
REQ-023: Simultaneous push and pop when empty SHALL leave the pushed value at the head.
REQ-024: A push when level = FIFO_DEPTH with no pop SHALL discard the new avg, leave FIFO contents unchanged, and set ovf.
REQ-025: ovf SHALL hold until ovf_clr=1 or reset; if ovf_clr=1 coincides with a new overflow, ovf SHALL remain 1.
REQ-026: flush=1 SHALL clear the accumulator and counter at the edge, and any y_in presented that edge SHALL be discarded; the FIFO and ovf SHALL be unaffected.
REQ-027: Read and write pointers SHALL wrap modulo FIFO_DEPTH; level SHALL equal write count minus read count.

Reset
REQ-028: When reset=0, the accumulator, counter, FIFO pointers, level, ovf, out_valid and dout SHALL go to 0 immediately, without waiting for clk.
REQ-029: Reset asserted mid-block SHALL discard the partial block and all queued averages.
REQ-030: After reset deasserts, the first accepted sample SHALL be sample 0 of a new block.

Verification
REQ-031: Scenario A (N=4, out_ready=1): feed 10,20,30,40 -> dout=25 with out_valid high for exactly one cycle, one cycle after the 40 edge.
REQ-032: Scenario B (rounding): feed -1,-2,-2,-2 -> dout=-2; feed 1,1,1,0 -> dout=1.
REQ-033: Scenario C (extremes): feed 127 x4 -> dout=127; feed -128 x4 -> dout=-128.
REQ-034: Scenario D (overflow): out_ready=0, five blocks of constants 1..5 -> level=4, ovf=1; then drain -> 1,2,3,4 in order, and ovf stays 1 until ovf_clr.
REQ-035: Scenario E (flush): feed 50,50, assert flush, then feed 8 x4 -> single output 8, level=1.
REQ-036: Scenario F (async reset): assert reset between clk edges with level=2 and counter=3 -> out_valid=0, level=0 and dout=0 before the next edge; the next 4 samples produce one correct average.
